// File: rtl/x_top_rv32i_param.sv
// Multi-cycle RV32I/RV32E integer core on a single valid/accept memory port.
// Illegal or misaligned operations park the core in HALT until reset.
module x_top_rv32i_param #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned NUM_REGS        = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_data,
  input  logic        i_accept,
  output logic        o_valid,
  output logic        o_rnw,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [3:0]  o_strb,
  output logic        o_halt
);
  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, HALT
  } state_t;

  state_t      state;
  logic [31:0] pc_q, ir_q, a_q, b_q, ea_q, wd_q;
  logic [3:0]  strb_q;
  logic        ill_q;
  logic [31:0] regs [NUM_REGS];

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign op  = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                  ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'd0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                  ir_q[20], ir_q[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_opi, is_op, is_fence;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;
  assign is_fence = op == 7'b0001111;

  logic [31:0] ra, rb;
  assign ra = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
  assign rb = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];

  // Opcode/funct legality plus the register fields each format uses
  logic ok, use_d, use_1, use_2, legal;
  always_comb begin
    ok    = 1'b0;
    use_d = 1'b0;
    use_1 = 1'b0;
    use_2 = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: begin
        ok    = 1'b1;
        use_d = 1'b1;
      end
      is_jalr: begin
        ok    = f3 == 3'd0;
        use_d = 1'b1;
        use_1 = 1'b1;
      end
      is_br: begin
        ok    = f3[2:1] != 2'b01;
        use_1 = 1'b1;
        use_2 = 1'b1;
      end
      is_ld: begin
        ok    = f3 != 3'd3 && f3 < 3'd6;
        use_d = 1'b1;
        use_1 = 1'b1;
      end
      is_st: begin
        ok    = f3 < 3'd3;
        use_1 = 1'b1;
        use_2 = 1'b1;
      end
      is_opi: begin
        ok = (f3 == 3'd1) ? f7 == 7'h00 :
             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        use_d = 1'b1;
        use_1 = 1'b1;
      end
      is_op: begin
        ok = f7 == 7'h00 ||
             (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        use_d = 1'b1;
        use_1 = 1'b1;
        use_2 = 1'b1;
      end
      is_fence: ok = f3 == 3'd0;
      default:  ok = 1'b0;
    endcase
  end

  assign legal = ok
    && (!use_d || 32'(rd)  < NUM_REGS)
    && (!use_1 || 32'(rs1) < NUM_REGS)
    && (!use_2 || 32'(rs2) < NUM_REGS);

  logic [31:0] ea_d, wd_d, mask_d;
  logic [3:0]  strb_d;
  logic        mis;
  assign ea_d = ra + (is_st ? imm_s : imm_i);
  assign mis  = (f3[1:0] == 2'b01 && ea_d[0]) ||
                (f3[1:0] == 2'b10 && ea_d[1:0] != 2'b00);
  always_comb begin
    unique case (f3[1:0])
      2'b00: begin
        strb_d = 4'b0001 << ea_d[1:0];
        wd_d   = {4{rb[7:0]}};
      end
      2'b01: begin
        strb_d = 4'b0011 << ea_d[1:0];
        wd_d   = {2{rb[15:0]}};
      end
      default: begin
        strb_d = 4'hF;
        wd_d   = rb;
      end
    endcase
  end
  assign mask_d = {{8{strb_d[3]}}, {8{strb_d[2]}},
                   {8{strb_d[1]}}, {8{strb_d[0]}}};

  logic [31:0] opb, alu, sra;
  logic [4:0]  sh;
  assign opb = is_op ? b_q : imm_i;
  assign sh  = opb[4:0];
  assign sra = $signed(a_q) >>> sh;
  always_comb begin
    unique case (f3)
      3'd0:    alu = (is_op && f7[5]) ? a_q - opb : a_q + opb;
      3'd1:    alu = a_q << sh;
      3'd2:    alu = {31'd0, $signed(a_q) < $signed(opb)};
      3'd3:    alu = {31'd0, a_q < opb};
      3'd4:    alu = a_q ^ opb;
      3'd5:    alu = f7[5] ? sra : a_q >> sh;
      3'd6:    alu = a_q | opb;
      default: alu = a_q & opb;
    endcase
  end

  logic take;
  always_comb begin
    unique case (f3)
      3'd0:    take = a_q == b_q;
      3'd1:    take = a_q != b_q;
      3'd4:    take = $signed(a_q) < $signed(b_q);
      3'd5:    take = $signed(a_q) >= $signed(b_q);
      3'd6:    take = a_q < b_q;
      3'd7:    take = a_q >= b_q;
      default: take = 1'b0;
    endcase
  end

  logic [31:0] nxt_pc, wb_val;
  logic        wb_en;
  always_comb begin
    nxt_pc = pc_q + 32'd4;
    wb_en  = 1'b0;
    wb_val = alu;
    if (!ill_q) begin
      unique case (1'b1)
        is_lui: begin
          wb_en  = 1'b1;
          wb_val = imm_u;
        end
        is_auipc: begin
          wb_en  = 1'b1;
          wb_val = pc_q + imm_u;
        end
        is_jal: begin
          wb_en  = 1'b1;
          wb_val = pc_q + 32'd4;
          nxt_pc = pc_q + imm_j;
        end
        is_jalr: begin
          wb_en  = 1'b1;
          wb_val = pc_q + 32'd4;
          nxt_pc = (a_q + imm_i) & ~32'd1;
        end
        is_br:         if (take) nxt_pc = pc_q + imm_b;
        is_opi, is_op: wb_en = 1'b1;
        default: ;
      endcase
    end
  end

  logic [31:0] lane, ld_val;
  assign lane = i_data >> {ea_q[1:0], 3'b000};
  always_comb begin
    unique case (f3)
      3'd0:    ld_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ld_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ld_val = {24'd0, lane[7:0]};
      3'd5:    ld_val = {16'd0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ea_q   <= '0;
      wd_q   <= '0;
      strb_q <= 4'hF;
      ill_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        FETCH: if (i_accept) begin
          ir_q  <= i_data;
          state <= DECODE;
        end
        DECODE: begin
          a_q    <= ra;
          b_q    <= rb;
          ea_q   <= ea_d;
          strb_q <= strb_d;
          wd_q   <= wd_d & mask_d;
          ill_q  <= !legal;
          if (!legal) begin
            if (HALT_ON_ILLEGAL) state <= HALT;
            else                 state <= EXECUTE;
          end else if (is_ld || is_st) begin
            if (mis) state <= HALT;
            else     state <= MEM;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          // A target with bit 1 set halts before any architectural update
          if (nxt_pc[1]) begin
            state <= HALT;
          end else begin
            pc_q  <= nxt_pc;
            state <= FETCH;
            if (wb_en && rd != 5'd0) regs[rd[RW-1:0]] <= wb_val;
          end
        end
        MEM: if (i_accept) begin
          pc_q  <= pc_q + 32'd4;
          state <= FETCH;
          if (is_ld && rd != 5'd0) regs[rd[RW-1:0]] <= ld_val;
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

  assign o_valid = state == FETCH || state == MEM;
  assign o_rnw   = (state == MEM) ? is_ld : 1'b1;
  assign o_addr  = (state == MEM) ? {ea_q[31:2], 2'b00} : pc_q;
  assign o_strb  = (state == MEM) ? strb_q : 4'hF;
  assign o_data  = (state == MEM && is_st) ? wd_q : '0;
  assign o_halt  = state == HALT;

endmodule

// File: tb/tb_x_top_rv32i_param.sv
// Scoreboarded bench: expected memory requests are queued with the
// program and matched against each request the core issues.
module tb_x_top_rv32i_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rdata, addr, wdata;
  logic        accept, valid, rnw, halt;
  logic [3:0]  strb;

  logic [31:0] rdata2, e_addr, e_data, h_addr, h_data;
  logic        acc_e, acc_h, e_valid, e_rnw, e_halt;
  logic        h_valid, h_rnw, h_halt;
  logic [3:0]  e_strb, h_strb;

  x_top_rv32i_param #(
    .RESET_PC(32'h100), .NUM_REGS(32), .HALT_ON_ILLEGAL(1'b1)
  ) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_data(rdata), .i_accept(accept),
    .o_valid(valid), .o_rnw(rnw), .o_addr(addr), .o_data(wdata),
    .o_strb(strb), .o_halt(halt)
  );

  x_top_rv32i_param #(
    .RESET_PC(32'h0), .NUM_REGS(16), .HALT_ON_ILLEGAL(1'b0)
  ) dut_e (
    .i_clk(clk), .i_nrst(rst_n), .i_data(rdata2), .i_accept(acc_e),
    .o_valid(e_valid), .o_rnw(e_rnw), .o_addr(e_addr), .o_data(e_data),
    .o_strb(e_strb), .o_halt(e_halt)
  );

  x_top_rv32i_param #(
    .RESET_PC(32'h0), .NUM_REGS(16), .HALT_ON_ILLEGAL(1'b1)
  ) dut_h (
    .i_clk(clk), .i_nrst(rst_n), .i_data(rdata2), .i_accept(acc_h),
    .o_valid(h_valid), .o_rnw(h_rnw), .o_addr(h_addr), .o_data(h_data),
    .o_strb(h_strb), .o_halt(h_halt)
  );

  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] JALR = 7'b1100111;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } req_t;

  req_t sb[$];
  int checks = 0;
  int errors = 0;
  int nreq = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                        int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                        int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic push(input logic r, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      input logic [31:0] rd, input int w);
    req_t e;
    e.rnw = r; e.addr = a; e.strb = s;
    e.wdata = wd; e.rdata = rd; e.waits = w;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins,
                       input int w);
    push(1'b1, pc, 4'hF, 32'h0, ins, w);
  endtask

  task automatic serve();
    req_t e;
    int n;
    string t;
    e = sb.pop_front();
    nreq++;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    t = $sformatf("req%0d", nreq);
    check({t, "_valid"}, 32'(valid), 32'd1);
    if (!valid) return;
    check({t, "_rnw"},  32'(rnw),  32'(e.rnw));
    check({t, "_addr"}, addr,      e.addr);
    check({t, "_strb"}, 32'(strb), 32'(e.strb));
    check({t, "_data"}, wdata,     e.rnw ? 32'h0 : e.wdata);
    for (int w = 0; w < e.waits; w++) begin
      @(negedge clk);
      check({t, "_hold_valid"}, 32'(valid), 32'd1);
      check({t, "_hold_addr"},  addr,       e.addr);
      check({t, "_hold_strb"},  32'(strb),  32'(e.strb));
      check({t, "_hold_rnw"},   32'(rnw),   32'(e.rnw));
    end
    rdata  = e.rdata;
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    rdata  = 32'hDEAD_BEEF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    accept = 1'b0; rdata = 32'h0;
    acc_e = 1'b0; acc_h = 1'b0; rdata2 = 32'h0;

    fetch(32'h100, enc_i(-5, 0, 0, 1, OPI), 3);
    fetch(32'h104, enc_s(0, 1, 0, 2), 0);
    push(1'b0, 32'h0, 4'hF, 32'hFFFF_FFFB, 32'h0, 0);
    fetch(32'h108, enc_i(1, 0, 0, 2, OPI), 0);
    fetch(32'h10C, enc_i(-1, 0, 0, 1, OPI), 0);
    fetch(32'h110, enc_b(16, 2, 1, 4), 0);
    fetch(32'h120, enc_b(16, 2, 1, 6), 0);
    fetch(32'h124, enc_b(-8, 0, 0, 0), 0);
    fetch(32'h11C, enc_i(32'hA5, 0, 0, 3, OPI), 0);
    fetch(32'h120, enc_i(32'h200, 0, 0, 4, OPI), 0);
    fetch(32'h124, enc_s(3, 3, 4, 0), 0);
    push(1'b0, 32'h200, 4'b1000, 32'hA500_0000, 32'h0, 0);
    fetch(32'h128, enc_i(3, 4, 0, 5, LD), 0);
    push(1'b1, 32'h200, 4'b1000, 32'h0, 32'h8012_3456, 0);
    fetch(32'h12C, enc_i(3, 4, 4, 6, LD), 0);
    push(1'b1, 32'h200, 4'b1000, 32'h0, 32'h8012_3456, 0);
    fetch(32'h130, enc_s(0, 5, 4, 2), 0);
    push(1'b0, 32'h200, 4'hF, 32'hFFFF_FF80, 32'h0, 0);
    fetch(32'h134, enc_s(4, 6, 4, 2), 0);
    push(1'b0, 32'h204, 4'hF, 32'h0000_0080, 32'h0, 0);
    fetch(32'h138, enc_i(7, 0, 0, 0, OPI), 0);
    fetch(32'h13C, enc_s(8, 0, 4, 2), 0);
    push(1'b0, 32'h208, 4'hF, 32'h0, 32'h0, 0);
    fetch(32'h140, enc_i(12, 4, 2, 7, LD), 0);
    push(1'b1, 32'h20C, 4'hF, 32'h0, 32'hCAFE_F00D, 5);
    fetch(32'h144, enc_r(32'h20, 1, 7, 0, 8), 0);
    fetch(32'h148, enc_i(32'h404, 5, 5, 9, OPI), 0);
    fetch(32'h14C, enc_r(0, 1, 2, 3, 10), 0);
    fetch(32'h150, enc_i(2, 4, 1, 11, LD), 1);
    push(1'b1, 32'h200, 4'b1100, 32'h0, 32'h8001_1234, 0);
    fetch(32'h154, enc_s(0, 7, 0, 2), 0);
    push(1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 0);
    fetch(32'h158, enc_s(4, 8, 0, 2), 0);
    push(1'b0, 32'h4, 4'hF, 32'hCAFE_F00E, 32'h0, 0);
    fetch(32'h15C, enc_s(8, 9, 0, 2), 0);
    push(1'b0, 32'h8, 4'hF, 32'hFFFF_FFF8, 32'h0, 0);
    fetch(32'h160, enc_s(12, 10, 0, 2), 0);
    push(1'b0, 32'hC, 4'hF, 32'h1, 32'h0, 0);
    fetch(32'h164, enc_s(16, 11, 0, 2), 0);
    push(1'b0, 32'h10, 4'hF, 32'hFFFF_8001, 32'h0, 0);
    fetch(32'h168, enc_s(2, 3, 4, 1), 0);
    push(1'b0, 32'h200, 4'b1100, 32'h00A5_0000, 32'h0, 0);
    fetch(32'h16C, enc_i(32'h40, 0, 0, 12, OPI), 0);
    fetch(32'h170, enc_i(0, 12, 0, 0, JALR), 0);
    fetch(32'h40, enc_j(8, 1), 0);
    fetch(32'h48, enc_s(0, 1, 0, 2), 0);
    push(1'b0, 32'h0, 4'hF, 32'h0000_0044, 32'h0, 0);
    fetch(32'h4C, enc_i(3, 1, 0, 0, JALR), 0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 32'(valid), 32'd1);
    check("rst_rnw",   32'(rnw),   32'd1);
    check("rst_addr",  addr,       32'h100);
    check("rst_strb",  32'(strb),  32'hF);
    check("rst_data",  wdata,      32'h0);
    check("rst_halt",  32'(halt),  32'd0);

    while (sb.size() > 0) serve();

    repeat (4) @(negedge clk);
    check("jalr_halt",  32'(halt),  32'd1);
    check("jalr_valid", 32'(valid), 32'd0);

    check("e_rst_addr", e_addr, 32'h0);
    rdata2 = enc_r(0, 2, 1, 0, 17);
    acc_e = 1'b1;
    acc_h = 1'b1;
    @(negedge clk);
    acc_e = 1'b0;
    @(negedge clk);
    check("h_halt",     32'(h_halt),  32'd1);
    check("h_valid",    32'(h_valid), 32'd0);
    check("e_exec_val", 32'(e_valid), 32'd0);
    @(negedge clk);
    check("e_nop_valid", 32'(e_valid), 32'd1);
    check("e_nop_addr",  e_addr,       32'h4);
    check("e_nop_halt",  32'(e_halt),  32'd0);
    repeat (3) @(negedge clk);
    check("h_sticky_halt",  32'(h_halt),  32'd1);
    check("h_sticky_valid", 32'(h_valid), 32'd0);
    acc_h = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
